mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-ported unified memory of the 64-bit MIPS core between the instruction-fetch requester and the load/store data requester. It sits between the core's fetch/memory stages and the memory (or cache) interface. It serialises accesses with a request/ack handshake, passes the 2-bit `memwrite` encoding through, and flags memories that never respond.

## Interface
- `ADDR_W`, 64: address width of all ports.
- `DATA_W`, 64: data width of all ports.
- `TIMEOUT`, 32: maximum wait in cycles for `m_ready` in a grant state; 0 disables the watchdog.
- `clk  in  1`: clock; all state changes on the rising edge.
- `reset  in  1`: asynchronous, active-low reset. Low forces the reset state immediately.
- `i_req  in  1`: fetch request; held high until `i_ack`.
- `i_addr  in  ADDR_W`: fetch address; stable while `i_req` is high.
- `i_rdata  out  DATA_W`: fetched data; valid in the `i_ack` cycle.
- `i_ack  out  1`: one-cycle completion pulse.
- `d_req  in  1`: data request; held high until `d_ack`.
- `d_we  in  2`: 00 means read; any nonzero value means write (core `memwrite` encoding).
- `d_addr  in  ADDR_W`, `d_wdata  in  DATA_W`: stable while `d_req` is high.
- `d_rdata  out  DATA_W`: load data; valid in the `d_ack` cycle.
- `d_ack  out  1`: one-cycle completion pulse.
- `m_req  out  1`, `m_we  out  2`, `m_addr  out  ADDR_W`, `m_wdata  out  DATA_W`: memory request, all registered.
- `m_rdata  in  DATA_W`, `m_ready  in  1`: memory response. `m_rdata` is valid when `m_ready` is high.
- `busy  out  1`: high in any state other than IDLE.
- `err  out  1`: sticky timeout flag.

## Operation
- States:
  - IDLE: no access in progress.
  - GNT_I: fetch access driving memory.
  - GNT_D: data access driving memory.
  - ACK: completion cycle.
- IDLE:
  - `i_req` alone goes to GNT_I; `d_req` alone goes to GNT_D.
  - When both are high, the tie-break under Configuration applies.
  - On entry to a grant state, the winner's address, data and `we` are latched into the `m_*` registers. For a fetch, `m_we` is 00. `m_req` is set to 1.
- GNT_x:
  - `m_req` stays high until `m_ready` is sampled high.
  - On that cycle: `m_req` goes to 0. If `m_we` is 00, `m_rdata` is captured into `x_rdata`; writes leave `x_rdata` unchanged. The state goes to ACK with `x_ack` = 1.
- ACK:
  - The requester drops its request during this cycle; the arbiter ignores the just-served requester's `req`.
  - If the other requester's `req` is high, the state goes directly to that requester's GNT. Otherwise it goes to IDLE.
  - `x_ack` returns to 0.
- `last_grant` records the most recent winner and resets to I.
- Watchdog (`TIMEOUT` > 0):
  - A counter clears on grant entry and increments each GNT cycle without `m_ready`.
  - When the counter reaches `TIMEOUT`: `m_req` goes to 0, `x_rdata` is set to 0, `err` is set to 1, and the state goes to ACK as for a normal completion.
  - `err` clears only on reset.
- Reset values: state IDLE, `last_grant` I. All outputs are 0: `m_*`, `i_ack`, `d_ack`, `i_rdata`, `d_rdata`, `busy` and `err`.
- Reset asserted mid-transaction aborts immediately. After reset, requesters must re-issue the request.

## Timing
- Request sampled at edge N gives `m_req` high from cycle N+1.
- `m_ready` sampled at edge M gives ack high in cycle M+1 with rdata valid.
- Zero-wait memory (`m_ready` high in the first `m_req` cycle) gives a request-to-ack latency of 2 cycles.
- A pending opposite request gives a back-to-back grant: its `m_req` rises in the cycle after ACK, with no IDLE bubble.
- `m_*` outputs never change while `m_req` is high.
- `i_ack` and `d_ack` are never high in the same cycle.
- `m_ready` outside GNT states is ignored.

## Configuration
- `ARB_RR_EN` defined: on a simultaneous request in IDLE or ACK, the requester not equal to `last_grant` wins (round-robin). After reset, the first tie goes to D.
- `ARB_RR_EN` undefined: fixed priority; D always wins ties.
- Non-tie behaviour is identical in both builds.

## Test plan
- **Single fetch:** `i_req` with `i_addr`=0x40; memory returns 0x20100005 after 2 wait cycles.
  - Expect `m_we`=00 and `m_addr`=0x40.
  - Expect one `i_ack` pulse with `i_rdata`=0x20100005.
  - Expect `busy` to fall after ACK.
- **Store:** `d_req`, `d_we`=01, `d_addr`=100, `d_wdata`=7, zero-wait memory.
  - Expect `m_we`=01, `m_addr`=100 and `m_wdata`=7.
  - Expect `d_ack` 2 cycles after the request; `d_rdata` stays 0.
- **Tie:** `i_req` and `d_req` rise in the same cycle, repeated 4 times.
  - Fixed build: D is served first in every tie.
  - `ARB_RR_EN` build: the service order is D, I, D, I; each second grant follows its ACK with no bubble.
- **Timeout:** `TIMEOUT`=32, `d_req` read, `m_ready` held low.
  - After 32 GNT cycles, expect `m_req` to drop, `d_ack`=1 with `d_rdata`=0, and `err`=1.
  - `err` stays 1 across later successful accesses.
- **Reset mid-access:** `reset` driven low while in GNT_I with `m_req` high.
  - Expect all outputs 0 immediately, without waiting for a clock edge.
  - After release, a fresh `d_req` is served normally.
- **Late response:** `m_ready` pulsed during IDLE and during ACK.
  - Expect no state change and no ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch (I) and
// load/store (D) requesters using a req/ack handshake. All m_* outputs are
// registered and held stable while m_req is high. A watchdog completes an
// access with zero data and raises a sticky err if the memory does not answer
// within TIMEOUT cycles (TIMEOUT = 0 disables it).
// Optional build macro: ARB_RR_EN selects round-robin tie-breaking; when it is
// undefined, D always wins a tie.
module mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic [1:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic [1:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ACK} state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    // Counter only has to reach TIMEOUT-1; the timeout fires on that cycle.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state, state_d;
    logic             last_grant;
    logic [CNT_W-1:0] wd_cnt;
    logic             cand_i, cand_d;
    logic             tie_d;
    logic             sel_i, sel_d;
    logic             in_gnt;
    logic             wd_hit;

    assign in_gnt = (state == GNT_I) || (state == GNT_D);
    assign wd_hit = (TIMEOUT > 0) && (wd_cnt == CNT_W'(TIMEOUT - 1));

`ifdef ARB_RR_EN
    // Round-robin: on a tie the requester that was not served last wins.
    assign tie_d = (last_grant == GRANT_I);
`else
    // Fixed priority: the data port always wins a tie.
    assign tie_d = 1'b1;
`endif

    // Candidates for a new grant; in ACK the requester just served is ignored.
    always_comb begin
        cand_i = 1'b0;
        cand_d = 1'b0;
        if (state == IDLE) begin
            cand_i = i_req;
            cand_d = d_req;
        end else if (state == ACK) begin
            cand_i = i_req & (last_grant == GRANT_D);
            cand_d = d_req & (last_grant == GRANT_I);
        end
        sel_d = cand_d & (~cand_i | tie_d);
        sel_i = cand_i & ~sel_d;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE, ACK: begin
                if (sel_d)              state_d = GNT_D;
                else if (sel_i)         state_d = GNT_I;
                else if (state == ACK)  state_d = IDLE;
            end
            GNT_I, GNT_D: begin
                if (m_ready || wd_hit)  state_d = ACK;
            end
            default:                    state_d = IDLE;
        endcase
    end

    // Decoded outputs.
    always_comb begin
        busy = (state != IDLE);
    end

    // Memory request registers, completion pulses, read data and watchdog.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_req      <= 1'b0;
            m_we       <= 2'b00;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            err        <= 1'b0;
            last_grant <= GRANT_I;
            wd_cnt     <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (sel_i || sel_d) begin
                m_req      <= 1'b1;
                m_we       <= sel_d ? d_we : 2'b00;
                m_addr     <= sel_d ? d_addr : i_addr;
                m_wdata    <= sel_d ? d_wdata : '0;
                last_grant <= sel_d ? GRANT_D : GRANT_I;
                wd_cnt     <= '0;
            end else if (in_gnt) begin
                if (m_ready) begin
                    m_req <= 1'b0;
                    if (state == GNT_D) begin
                        d_ack <= 1'b1;
                        if (m_we == 2'b00) d_rdata <= m_rdata;
                    end else begin
                        i_ack <= 1'b1;
                        if (m_we == 2'b00) i_rdata <= m_rdata;
                    end
                end else if (wd_hit) begin
                    m_req <= 1'b0;
                    err   <= 1'b1;
                    if (state == GNT_D) begin
                        d_ack   <= 1'b1;
                        d_rdata <= '0;
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= '0;
                    end
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// transaction-level model (expected grant order, latency, held read data and
// sticky error flag). Inputs are driven and outputs sampled on the falling edge.
module tb_mem_arbiter;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_rdata;
    logic          i_ack;
    logic          d_req = 1'b0;
    logic [1:0]    d_we = 2'b00;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          m_req;
    logic [1:0]    m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata = '0;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          err;

    int vectors = 0;
    int miss = 0;

    // Model state.
    logic [DW-1:0] exp_i = '0;
    logic [DW-1:0] exp_d = '0;
    logic          exp_err = 1'b0;
    logic          last_d = 1'b0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mreq"}, m_req, 0);
        chk({tag, "_acks"}, {i_ack, d_ack}, 0);
        chk({tag, "_irdata"}, i_rdata, exp_i);
        chk({tag, "_drdata"}, d_rdata, exp_d);
        chk({tag, "_err"}, err, exp_err);
    endtask

    // Called in the first cycle m_req should be high for this requester.
    // Answers after w wait cycles, then checks the ack cycle and drops req.
    task automatic serve(input bit is_d, input int w, input logic [63:0] rdv, input bit late);
        logic [63:0] ea;
        logic [1:0]  ew;
        ea = is_d ? d_addr : i_addr;
        ew = is_d ? d_we : 2'b00;
        chk("grant_req", m_req, 1);
        chk("grant_addr", m_addr, ea);
        chk("grant_we", m_we, ew);
        if (is_d) chk("grant_wdata", m_wdata, d_wdata);
        chk("grant_busy", busy, 1);
        for (int k = 0; k <= w; k++) begin
            m_ready = (k == w);
            m_rdata = (k == w) ? rdv : rnd64();
            step();
            if (k < w) begin
                chk("wait_req", m_req, 1);
                chk("wait_addr", m_addr, ea);
                chk("wait_we", m_we, ew);
                chk("wait_acks", {i_ack, d_ack}, 0);
            end
        end
        if (!is_d) exp_i = rdv;
        else if (d_we == 2'b00) exp_d = rdv;
        chk("ack_i", i_ack, !is_d);
        chk("ack_d", d_ack, is_d);
        chk("ack_irdata", i_rdata, exp_i);
        chk("ack_drdata", d_rdata, exp_d);
        chk("ack_mreq", m_req, 0);
        chk("ack_busy", busy, 1);
        chk("ack_err", err, exp_err);
        last_d = is_d;
        if (is_d) d_req = 1'b0;
        else      i_req = 1'b0;
        // Optional stray response during ACK; it must be ignored.
        m_ready = late;
        m_rdata = rnd64();
    endtask

    task automatic single(input bit is_d, input int w, input logic [63:0] rdv, input bit late);
        if (is_d) d_req = 1'b1;
        else      i_req = 1'b1;
        step();
        serve(is_d, w, rdv, late);
        step();
        m_ready = 1'b0;
        chk_idle("after_single");
    endtask

    task automatic tie(input int w1, input int w2);
        bit first_d;
        i_req = 1'b1;
        d_req = 1'b1;
`ifdef ARB_RR_EN
        first_d = !last_d;
`else
        first_d = 1'b1;
`endif
        step();
        serve(first_d, w1, rnd64(), 1'b0);
        step();
        serve(!first_d, w2, rnd64(), 1'b0);
        step();
        m_ready = 1'b0;
        chk_idle("after_tie");
    endtask

    initial begin
        // Reset state.
        #1 reset = 1'b0;
        #2;
        chk("rst_mreq", m_req, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_we", m_we, 0);
        chk_idle("rst");
        step();
        reset = 1'b1;
        step();
        chk_idle("post_rst");

        // Single fetch with two wait cycles.
        i_addr = 64'h40;
        single(1'b0, 2, 64'h20100005, 1'b0);
        chk("fetch_rdata", i_rdata, 64'h20100005);

        // Zero-wait store: d_rdata must stay at its reset value.
        d_addr = 64'd100; d_we = 2'b01; d_wdata = 64'd7;
        single(1'b1, 0, rnd64(), 1'b0);
        chk("store_drdata", d_rdata, 0);

        // Four simultaneous requests.
        for (int t = 0; t < 4; t++) begin
            i_addr = rnd64(); d_addr = rnd64(); d_wdata = rnd64();
            d_we = 2'($urandom_range(0, 3));
            tie($urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Stray response while idle.
        m_ready = 1'b1; m_rdata = rnd64();
        step();
        m_ready = 1'b0;
        chk_idle("late_idle1");
        step();
        chk_idle("late_idle2");

        // Watchdog: read with no response.
        d_addr = rnd64(); d_we = 2'b00; d_req = 1'b1; m_ready = 1'b0;
        step();
        for (int k = 0; k < TO; k++) begin
            chk("to_mreq", m_req, 1);
            chk("to_dack", d_ack, 0);
            chk("to_err", err, 0);
            step();
        end
        exp_d = '0;
        exp_err = 1'b1;
        chk("to_ack", d_ack, 1);
        chk("to_mreq_drop", m_req, 0);
        chk("to_drdata", d_rdata, 0);
        chk("to_err_set", err, 1);
        d_req = 1'b0;
        last_d = 1'b1;
        step();
        chk_idle("after_to");

        // Randomized mix; err must remain set throughout.
        for (int n = 0; n < 40; n++) begin
            int mode;
            mode = $urandom_range(0, 2);
            i_addr = rnd64(); d_addr = rnd64(); d_wdata = rnd64();
            d_we = 2'($urandom_range(0, 3));
            if (mode == 2) tie($urandom_range(0, 4), $urandom_range(0, 4));
            else single(mode == 1, $urandom_range(0, 4), rnd64(), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a fetch grant.
        i_addr = rnd64();
        i_req = 1'b1;
        step();
        chk("mid_mreq", m_req, 1);
        #2 reset = 1'b0;
        #1;
        exp_i = '0; exp_d = '0; exp_err = 1'b0; last_d = 1'b0;
        chk("mid_rst_mreq", m_req, 0);
        chk("mid_rst_maddr", m_addr, 0);
        chk("mid_rst_mwdata", m_wdata, 0);
        chk("mid_rst_mwe", m_we, 0);
        chk_idle("mid_rst");
        i_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk_idle("mid_rel");

        // Fresh data read after reset.
        d_addr = rnd64(); d_we = 2'b00; d_wdata = rnd64();
        single(1'b1, 1, rnd64(), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

endmodule
